frame_ram_arbiter: RTL and testbench

- Shares the single-port frame RAM between two users:
  - the VGA-side reader, which has absolute priority;
  - the serial (UART) image loader.
- Packs incoming serial bytes into RAM_WIDTH-bit words and holds them in a small FIFO.
- Writes queued words into the RAM only on cycles where the reader is not requesting, for example during blanking.
- Tracks the write pointer, wraps it at frame end and flags dropped data.

---
 rtl/frame_ram_arbiter_if.sv | 31 +++
 rtl/frame_ram_arbiter.sv | 115 +++++++++++
 tb/tb_frame_ram_arbiter.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_ram_arbiter_if.sv
// Bus bundle between the frame RAM arbiter, its two users and the RAM itself.
interface frame_ram_if #(
  parameter int RAM_WIDTH    = 32,
  parameter int ADDRESS_BITS = 17,
  parameter int LEVEL_W      = 3
);
  logic [7:0]              rx_data;
  logic                    rx_valid;
  logic                    frame_start;
  logic                    rd_req;
  logic [ADDRESS_BITS-1:0] rd_addr;
  logic [RAM_WIDTH-1:0]    rd_data;
  logic                    rd_valid;
  logic [ADDRESS_BITS-1:0] ram_addr;
  logic [RAM_WIDTH-1:0]    ram_wdata;
  logic                    ram_we;
  logic [RAM_WIDTH-1:0]    ram_rdata;
  logic                    overflow;
  logic                    frame_done;
  logic [LEVEL_W-1:0]      fifo_level;

  modport master (
    output rx_data, rx_valid, frame_start, rd_req, rd_addr, ram_rdata,
    input  rd_data, rd_valid, ram_addr, ram_wdata, ram_we, overflow, frame_done, fifo_level
  );

  modport slave (
    input  rx_data, rx_valid, frame_start, rd_req, rd_addr, ram_rdata,
    output rd_data, rd_valid, ram_addr, ram_wdata, ram_we, overflow, frame_done, fifo_level
  );
endinterface

// File: rtl/frame_ram_arbiter.sv
// Shares a single-port frame RAM between a priority reader and a serial byte loader
// that packs bytes into words, queues them and writes them in the reader's idle cycles.
module frame_ram_arbiter #(
  parameter int RAM_WIDTH  = 32,
  parameter int N_BITS     = 480*360*24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  frame_ram_if.slave bus
);
  localparam int RAM_DEPTH    = N_BITS / RAM_WIDTH;
  localparam int MAX_ADDRESS  = RAM_DEPTH - 1;
  localparam int ADDRESS_BITS = $clog2(RAM_DEPTH);
  localparam int LANES        = RAM_WIDTH / 8;
  localparam int LANE_W       = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int LVL_W        = PTR_W + 1;

  logic [LANE_W-1:0]       byte_cnt;
  logic [RAM_WIDTH-1:0]    pack;
  logic [RAM_WIDTH-1:0]    word;
  logic [RAM_WIDTH-1:0]    fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        head;
  logic [PTR_W-1:0]        tail;
  logic [LVL_W-1:0]        level;
  logic [ADDRESS_BITS-1:0] wr_ptr;
  logic                    overflow_r;
  logic                    frame_done_r;
  logic                    rd_vld_p1;
  logic [RAM_WIDTH-1:0]    rd_data_p1;
  logic                    last_lane;
  logic                    push;
  logic                    accept;
  logic                    pop;
  logic                    full;
  logic                    empty;

  assign last_lane = (byte_cnt == LANE_W'(LANES - 1));
  assign full      = (level == LVL_W'(FIFO_DEPTH));
  assign empty     = (level == '0);
  assign push      = bus.rx_valid && last_lane && !bus.frame_start;
  // A full FIFO still takes the new word when the head leaves in the same cycle.
  assign accept    = push && (!full || pop);

  always_comb begin
    word = pack;
    word[int'(byte_cnt)*8 +: 8] = bus.rx_data;
  end

  // The reader always wins; queued words only go out on cycles it leaves free.
  always_comb begin
    pop           = !bus.rd_req && !empty && !bus.frame_start;
    bus.ram_we    = pop;
    bus.ram_addr  = bus.rd_req ? bus.rd_addr : wr_ptr;
    bus.ram_wdata = fifo_mem[head];
  end

  always_ff @(posedge clk) begin
    if (bus.rx_valid) begin
      if (bus.frame_start) pack[7:0] <= bus.rx_data;
      else                 pack      <= word;
    end
    if (accept) fifo_mem[tail] <= word;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt     <= '0;
      head         <= '0;
      tail         <= '0;
      level        <= '0;
      wr_ptr       <= '0;
      overflow_r   <= 1'b0;
      frame_done_r <= 1'b0;
    end else if (bus.frame_start) begin
      byte_cnt     <= bus.rx_valid ? LANE_W'(1) : '0;
      head         <= '0;
      tail         <= '0;
      level        <= '0;
      wr_ptr       <= '0;
      overflow_r   <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      if (bus.rx_valid) byte_cnt <= last_lane ? '0 : byte_cnt + 1'b1;
      if (accept) tail <= tail + 1'b1;
      if (pop)    head <= head + 1'b1;
      case ({accept, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (push && !accept) overflow_r <= 1'b1;
      if (pop) wr_ptr <= (wr_ptr == ADDRESS_BITS'(MAX_ADDRESS)) ? '0 : wr_ptr + 1'b1;
      frame_done_r <= pop && (wr_ptr == ADDRESS_BITS'(MAX_ADDRESS));
    end
  end

  // Read return stage: data and valid leave together one cycle after the request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_vld_p1  <= 1'b0;
      rd_data_p1 <= '0;
    end else begin
      rd_vld_p1  <= bus.rd_req;
      rd_data_p1 <= bus.rd_req ? bus.ram_rdata : '0;
    end
  end

  assign bus.rd_valid   = rd_vld_p1;
  assign bus.rd_data    = rd_data_p1;
  assign bus.overflow   = overflow_r;
  assign bus.frame_done = frame_done_r;
  assign bus.fifo_level = level;
endmodule

// File: tb/tb_frame_ram_arbiter.sv
// Bench for frame_ram_arbiter: packing vectors from a table, RAM writes checked
// against a scoreboard of expected {address, word}, plus hand-written corner sequences.
module tb_frame_ram_arbiter;
  localparam int RW    = 32;
  localparam int NB    = 16 * 32;
  localparam int FD    = 4;
  localparam int DEPTH = NB / RW;
  localparam int MAXA  = DEPTH - 1;
  localparam int AB    = $clog2(DEPTH);
  localparam int LVLW  = $clog2(FD) + 1;

  logic clk;
  logic rst;

  frame_ram_if #(.RAM_WIDTH(RW), .ADDRESS_BITS(AB), .LEVEL_W(LVLW)) bus ();

  frame_ram_arbiter #(.RAM_WIDTH(RW), .N_BITS(NB), .FIFO_DEPTH(FD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [AB-1:0] addr;
    logic [RW-1:0] data;
  } wr_t;

  typedef struct {
    logic [7:0]    b0, b1, b2, b3;
    logic [RW-1:0] word;
  } vec_t;

  wr_t     sb[$];
  int      passed = 0;
  int      total  = 0;
  int      fd_count = 0;
  int      exp_ptr = 0;
  bit      chk_rd = 0;
  logic [AB-1:0] exp_rd_addr = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [RW-1:0] w, input bit expect_write);
    wr_t e;
    for (int k = 0; k < RW / 8; k++) send_byte(w[k*8 +: 8]);
    if (expect_write) begin
      e.addr = AB'(exp_ptr);
      e.data = w;
      sb.push_back(e);
      exp_ptr = (exp_ptr == MAXA) ? 0 : exp_ptr + 1;
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (bus.fifo_level != 0 && n < 50) begin
      tick();
      n++;
    end
    check({name, "_drain"}, bus.fifo_level, 0);
    check({name, "_sb_empty"}, sb.size(), 0);
  endtask

  // Write scoreboard and read-priority watcher, sampled mid-cycle.
  always @(negedge clk) begin
    wr_t e;
    if (rst && bus.ram_we) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h, required no write", bus.ram_addr, bus.ram_wdata);
      end else begin
        e = sb.pop_front();
        check("wr_addr", bus.ram_addr, e.addr);
        check("wr_data", bus.ram_wdata, e.data);
      end
    end
    if (chk_rd) begin
      check("rd_prio_we", bus.ram_we, 0);
      check("rd_prio_addr", bus.ram_addr, exp_rd_addr);
      if (bus.rd_valid) check("rd_data_during", bus.rd_data, bus.ram_rdata);
    end
    if (rst && bus.frame_done) fd_count++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs [6];
    vecs[0] = '{8'h11, 8'h22, 8'h33, 8'h44, 32'h44332211};
    vecs[1] = '{8'h00, 8'h00, 8'h00, 8'h00, 32'h00000000};
    vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'hFFFFFFFF};
    vecs[3] = '{8'hA5, 8'h5A, 8'hC3, 8'h3C, 32'h3CC35AA5};
    vecs[4] = '{8'h01, 8'h02, 8'h04, 8'h80, 32'h80040201};
    vecs[5] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 32'hEFBEADDE};

    rst = 1'b0;
    bus.rx_data = '0; bus.rx_valid = 0; bus.frame_start = 0;
    bus.rd_req = 0; bus.rd_addr = '0; bus.ram_rdata = '0;

    // Reset held with random activity on the inputs
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus.rx_data     = 8'($urandom);
      bus.rx_valid    = 1'($urandom);
      bus.frame_start = 1'($urandom);
      bus.rd_req      = 1'($urandom);
      bus.rd_addr     = AB'($urandom);
      bus.ram_rdata   = 32'($urandom);
      @(negedge clk);
      check("rst_ram_we", bus.ram_we, 0);
      check("rst_rd_valid", bus.rd_valid, 0);
      check("rst_overflow", bus.overflow, 0);
      check("rst_fifo_level", bus.fifo_level, 0);
    end
    tick();
    bus.rx_valid = 0; bus.frame_start = 0; bus.rd_req = 0; bus.ram_rdata = '0;
    rst = 1'b1;
    tick();

    // Table-driven packing
    for (int i = 0; i < 6; i++) begin
      send_byte(vecs[i].b0);
      send_byte(vecs[i].b1);
      send_byte(vecs[i].b2);
      send_byte(vecs[i].b3);
      sb.push_back('{AB'(exp_ptr), vecs[i].word});
      exp_ptr++;
      if (i == 0) begin
        tick();
        check("wr_ptr_after_first", bus.ram_addr, 1);
      end
    end
    wait_drain("table");
    check("idle_addr_is_wr_ptr", bus.ram_addr, exp_ptr);

    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    exp_ptr = 0;
    check("fs_level", bus.fifo_level, 0);
    check("fs_idle_addr", bus.ram_addr, 0);

    // Read priority with two words queued
    bus.rd_req = 1'b1; bus.rd_addr = AB'(5); exp_rd_addr = AB'(5);
    bus.ram_rdata = 32'hCAFEF00D; chk_rd = 1'b1;
    tick();
    check("rd_valid_lat", bus.rd_valid, 1);
    check("rd_data_lat", bus.rd_data, 32'hCAFEF00D);
    send_word(32'h0BADBEEF, 1);
    send_word(32'h76543210, 1);
    check("rd_hold_level", bus.fifo_level, 2);
    check("rd_valid_last", bus.rd_valid, 1);
    bus.rd_req = 1'b0; chk_rd = 1'b0;
    tick();
    check("rd_valid_drop", bus.rd_valid, 0);
    check("rd_data_black", bus.rd_data, 0);
    check("burst_level_1", bus.fifo_level, 1);
    tick();
    check("burst_level_0", bus.fifo_level, 0);
    check("burst_sb_empty", sb.size(), 0);

    // Overflow while the reader starves the writer
    bus.rd_req = 1'b1; bus.rd_addr = AB'(9); exp_rd_addr = AB'(9);
    bus.ram_rdata = 32'h13579BDF; chk_rd = 1'b1;
    for (int i = 0; i < FD + 1; i++) send_word(32'hA0000000 + 32'(i), i < FD);
    check("ovf_level", bus.fifo_level, FD);
    check("ovf_flag", bus.overflow, 1);
    bus.rd_req = 1'b0; chk_rd = 1'b0;
    wait_drain("ovf");
    check("ovf_sticky", bus.overflow, 1);

    // frame_start mid-word with a queued word and a pending write
    bus.rd_req = 1'b1; chk_rd = 1'b1;
    send_word(32'h12345678, 0);
    check("fsm_level_before", bus.fifo_level, 1);
    send_byte(8'h77);
    send_byte(8'h88);
    bus.rd_req = 1'b0; chk_rd = 1'b0;
    bus.frame_start = 1'b1; bus.rx_data = 8'hAA; bus.rx_valid = 1'b1;
    #2;
    check("fsm_we_suppressed", bus.ram_we, 0);
    tick();
    bus.frame_start = 1'b0; bus.rx_valid = 1'b0;
    exp_ptr = 0;
    check("fsm_flushed", bus.fifo_level, 0);
    check("fsm_ovf_clear", bus.overflow, 0);
    send_byte(8'hBB);
    send_byte(8'hCC);
    send_byte(8'hDD);
    sb.push_back('{AB'(0), 32'hDDCCBBAA});
    exp_ptr = 1;
    wait_drain("fsm");

    // Fill to the last address and watch the wrap
    for (int i = 1; i < MAXA; i++) send_word(32'h10000000 + 32'(i), 1);
    wait_drain("fill");
    check("fd_none_yet", fd_count, 0);
    send_word(32'hF00DF00D, 1);
    check("fd_write_cycle", bus.frame_done, 0);
    tick();
    check("fd_pulse", bus.frame_done, 1);
    check("wrap_addr", bus.ram_addr, 0);
    tick();
    check("fd_single", bus.frame_done, 0);
    send_word(32'h0000A000, 1);
    wait_drain("wrap");

    // Asynchronous reset during a write, with a partial word pending
    bus.rd_req = 1'b1; bus.rd_addr = AB'(9); exp_rd_addr = AB'(9); chk_rd = 1'b1;
    send_word(32'h55555555, 0);
    send_word(32'h66666666, 0);
    send_byte(8'h01);
    send_byte(8'h02);
    check("ar_level_before", bus.fifo_level, 2);
    bus.rd_req = 1'b0; chk_rd = 1'b0;
    #2;
    check("ar_we_before", bus.ram_we, 1);
    rst = 1'b0;
    #1;
    check("ar_we_falls", bus.ram_we, 0);
    tick();
    rst = 1'b1;
    exp_ptr = 0;
    check("ar_level", bus.fifo_level, 0);
    check("ar_wr_ptr", bus.ram_addr, 0);
    send_word(32'hA1B2C3D4, 1);
    wait_drain("ar");

    check("fd_total", fd_count, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
